// File: rtl/multi_cycle_adder.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_adder
//  Description : WIDTH-bit adder that adds SLICE bits per clock through one
//                ripple slice, with a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_adder #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s_out,
   output logic             c_out,
   output logic             overflow
);

   localparam int c_n_slices = WIDTH / SLICE;
   localparam int c_idx_w    = $clog2(c_n_slices + 1);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_n_slices - 1);
   localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

   generate
      if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
         $error("multi_cycle_adder: SLICE must be >= 1 and divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic [c_idx_w-1:0] r_idx;

   logic [SLICE:0]     w_c;
   logic [SLICE-1:0]   w_s;
   logic [WIDTH-1:0]   w_s_ext;
   logic [WIDTH-1:0]   w_sum_next;

   // Operands shift right each RUN cycle, so the active slice is always bits [SLICE-1:0].
   assign w_c[0] = r_carry;

   genvar gi;
   generate
      for (gi = 0; gi < SLICE; gi++) begin : g_ripple
         assign w_s[gi]   = r_a[gi] ^ r_b[gi] ^ w_c[gi];
         assign w_c[gi+1] = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
      end
   endgenerate

   always_comb begin
      w_s_ext             = '0;
      w_s_ext[SLICE-1:0]  = w_s;
   end

   // Sum bits enter at the top and shift down, landing in place after the last slice.
   assign w_sum_next = (r_sum >> SLICE) | (w_s_ext << (WIDTH - SLICE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         s_out    <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= c_in;
                  r_idx   <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  busy    <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> SLICE;
               r_b     <= r_b >> SLICE;
               r_sum   <= w_sum_next;
               r_carry <= w_c[SLICE];
               r_idx   <= r_idx + c_idx_one;
               if (r_idx == c_last_idx) begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  s_out    <= w_sum_next;
                  c_out    <= w_c[SLICE];
                  overflow <= w_c[SLICE] ^ w_c[SLICE-1];
                  r_state  <= ST_DONE;
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_cycle_adder
//  Description : Directed-vector and randomised bench for multi_cycle_adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_adder;

   logic clk;
   logic rst;

   // WIDTH=1, SLICE=1
   logic st1, a1, b1, ci1, busy1, done1, s1, co1, ov1;

   // WIDTH=8, SLICE=1 and SLICE=4 share operands, separate starts
   logic [7:0] a8, b8, s8_1, s8_4;
   logic       ci8, st8_1, st8_4;
   logic       busy8_1, done8_1, co8_1, ov8_1;
   logic       busy8_4, done8_4, co8_4, ov8_4;

   // WIDTH=16, SLICE = 1,2,4,8,16 all fed together
   logic [15:0] a16, b16;
   logic        ci16, st16;
   logic [15:0] s16    [5];
   logic        busy16 [5];
   logic        done16 [5];
   logic        co16   [5];
   logic        ov16   [5];

   int n_vec = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   multi_cycle_adder #(.WIDTH(1), .SLICE(1)) u_w1 (
      .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .c_in(ci1),
      .busy(busy1), .done(done1), .s_out(s1), .c_out(co1), .overflow(ov1));

   multi_cycle_adder #(.WIDTH(8), .SLICE(1)) u_w8s1 (
      .clk(clk), .rst(rst), .start(st8_1), .a(a8), .b(b8), .c_in(ci8),
      .busy(busy8_1), .done(done8_1), .s_out(s8_1), .c_out(co8_1), .overflow(ov8_1));

   multi_cycle_adder #(.WIDTH(8), .SLICE(4)) u_w8s4 (
      .clk(clk), .rst(rst), .start(st8_4), .a(a8), .b(b8), .c_in(ci8),
      .busy(busy8_4), .done(done8_4), .s_out(s8_4), .c_out(co8_4), .overflow(ov8_4));

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_w16
         multi_cycle_adder #(.WIDTH(16), .SLICE(1 << gi)) u_dut (
            .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .c_in(ci16),
            .busy(busy16[gi]), .done(done16[gi]), .s_out(s16[gi]),
            .c_out(co16[gi]), .overflow(ov16[gi]));
      end
   endgenerate

   typedef struct packed {
      logic a, b, ci;
      logic s, co;
   } fa_vec_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [7:0] s;
      logic       co;
      logic       ov;
      logic       s4;   // 1: apply to the SLICE=4 instance
   } vec8_t;

   fa_vec_t fa_tab [8];
   vec8_t   tab8   [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic run8(input vec8_t v, input int idx);
      int n;
      n = v.s4 ? 2 : 8;
      a8 = v.a; b8 = v.b; ci8 = v.ci;
      if (v.s4) st8_4 = 1'b1; else st8_1 = 1'b1;
      tick();
      st8_1 = 1'b0; st8_4 = 1'b0;
      chk($sformatf("v8[%0d] busy/done at E0", idx),
          v.s4 ? {busy8_4, done8_4} : {busy8_1, done8_1}, 2'b10);
      for (int k = 1; k <= n; k++) begin
         tick();
         if (k < n) begin
            chk($sformatf("v8[%0d] busy/done cycle %0d", idx, k),
                v.s4 ? {busy8_4, done8_4} : {busy8_1, done8_1}, 2'b10);
         end else begin
            chk($sformatf("v8[%0d] busy/done at E0+N", idx),
                v.s4 ? {busy8_4, done8_4} : {busy8_1, done8_1}, 2'b01);
            chk($sformatf("v8[%0d] s_out", idx), v.s4 ? s8_4 : s8_1, v.s);
            chk($sformatf("v8[%0d] c_out", idx), v.s4 ? co8_4 : co8_1, v.co);
            chk($sformatf("v8[%0d] overflow", idx), v.s4 ? ov8_4 : ov8_1, v.ov);
         end
      end
      tick();
      chk($sformatf("v8[%0d] done single pulse", idx),
          v.s4 ? {busy8_4, done8_4} : {busy8_1, done8_1}, 2'b00);
   endtask

   initial begin : main
      logic [16:0] exp17;
      logic        exp_ov;
      logic [1:0]  exp_bd;
      int          n;
      int          seen;

      // full-adder truth table: {a, b, ci, s, co}
      fa_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      fa_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      fa_tab[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      fa_tab[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      fa_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      fa_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      fa_tab[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      fa_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      // {a, b, ci, s, co, ov, s4}
      tab8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      tab8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      tab8[2] = '{8'h3C, 8'hC5, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1};
      tab8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      tab8[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
      tab8[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tab8[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1};
      tab8[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1};

      rst = 1'b1;
      st1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
      st8_1 = 1'b0; st8_4 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
      st16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;

      tick();
      chk("reset w8s1 flags", {busy8_1, done8_1, co8_1, ov8_1}, 4'b0000);
      chk("reset w8s1 s_out", s8_1, 8'h00);
      chk("reset w8s4 outputs", {busy8_4, done8_4, co8_4, ov8_4, s8_4}, 12'h000);
      chk("reset w1 outputs", {busy1, done1, s1, co1, ov1}, 5'b00000);
      #3 rst = 1'b0;
      tick();

      // WIDTH=1 full-adder table
      for (int i = 0; i < 8; i++) begin
         a1 = fa_tab[i].a; b1 = fa_tab[i].b; ci1 = fa_tab[i].ci; st1 = 1'b1;
         tick();
         st1 = 1'b0;
         chk($sformatf("fa[%0d] busy/done at E0", i), {busy1, done1}, 2'b10);
         tick();
         chk($sformatf("fa[%0d] busy/done at E0+1", i), {busy1, done1}, 2'b01);
         chk($sformatf("fa[%0d] s/c", i), {s1, co1}, {fa_tab[i].s, fa_tab[i].co});
         tick();
         chk($sformatf("fa[%0d] done single pulse", i), {busy1, done1}, 2'b00);
      end

      // WIDTH=8 table
      for (int i = 0; i < 8; i++) run8(tab8[i], i);

      // start held high, operands and start toggled during RUN, back-to-back in DONE
      a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0; st8_1 = 1'b1;
      tick();
      chk("held E0 busy/done", {busy8_1, done8_1}, 2'b10);
      a8 = 8'hF0; b8 = 8'hF0; ci8 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 3) st8_1 = 1'b0;
         if (k == 4) st8_1 = 1'b1;
         if (k < 8) chk($sformatf("held run cycle %0d busy/done", k), {busy8_1, done8_1}, 2'b10);
      end
      chk("held first done", {busy8_1, done8_1}, 2'b01);
      chk("held first s_out", s8_1, 8'h33);
      chk("held first c/ov", {co8_1, ov8_1}, 2'b00);
      tick();
      chk("b2b accepted in DONE", {busy8_1, done8_1}, 2'b10);
      st8_1 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k < 8) chk($sformatf("b2b cycle %0d busy/done", k), {busy8_1, done8_1}, 2'b10);
      end
      chk("b2b done at DONE edge + 8", {busy8_1, done8_1}, 2'b01);
      chk("b2b s_out", s8_1, 8'hE1);
      chk("b2b c/ov", {co8_1, ov8_1}, 2'b10);
      tick();
      chk("b2b done single pulse", {busy8_1, done8_1}, 2'b00);

      // asynchronous reset in RUN cycle 3
      a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; st8_1 = 1'b1;
      tick();
      st8_1 = 1'b0;
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("async reset flags", {busy8_1, done8_1, co8_1, ov8_1}, 4'b0000);
      chk("async reset s_out", s8_1, 8'h00);
      tick();
      #2 rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done8_1 !== 1'b0 || busy8_1 !== 1'b0) seen++;
      end
      chk("no activity after reset abort", seen, 0);
      run8(tab8[0], 100);

      // randomised WIDTH=16 across all slice widths
      for (int it = 0; it < 1000; it++) begin
         a16  = 16'($urandom);
         b16  = 16'($urandom);
         ci16 = 1'($urandom_range(0, 1));
         st16 = 1'b1;
         exp17  = {1'b0, a16} + {1'b0, b16} + {16'h0000, ci16};
         exp_ov = (a16[15] == b16[15]) && (exp17[15] != a16[15]);
         tick();
         st16 = 1'b0;
         for (int k = 1; k <= 16; k++) begin
            tick();
            for (int i = 0; i < 5; i++) begin
               n = 16 >> i;
               exp_bd = (k < n) ? 2'b10 : ((k == n) ? 2'b01 : 2'b00);
               chk($sformatf("rnd[%0d] slice%0d cycle %0d busy/done", it, 1 << i, k),
                   {busy16[i], done16[i]}, exp_bd);
               if (k == n) begin
                  chk($sformatf("rnd[%0d] slice%0d {c_out,s_out} a=%h b=%h ci=%b",
                                it, 1 << i, a16, b16, ci16),
                      {co16[i], s16[i]}, exp17);
                  chk($sformatf("rnd[%0d] slice%0d overflow", it, 1 << i), ov16[i], exp_ov);
               end
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
